// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count and threshold flags; data_out is registered (1-cycle read latency) or fall-through.
// No backpressure: a write while full is dropped unless paired with a read, and the drop or an empty read pulses overflow/underflow.
module sync_fifo_flags #(
   parameter int W     = 32,
   parameter int D     = 3,
   parameter int AF_TH = 6,
   parameter int AE_TH = 2,
   parameter bit FWFT  = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wrt_en,
   input  logic [W-1:0] data_in,
   input  logic         rd_en,
   output logic [W-1:0] data_out,
   output logic [D:0]   count,
   output logic         full,
   output logic         empty,
   output logic         almost_full,
   output logic         almost_empty,
   output logic         overflow,
   output logic         underflow
);

   localparam int         DEPTH    = 1 << D;
   localparam logic [D:0] CNT_FULL = (D+1)'(DEPTH);
   localparam logic [D:0] CNT_AF   = (D+1)'(AF_TH);
   localparam logic [D:0] CNT_AE   = (D+1)'(AE_TH);
   localparam logic [D:0] CNT_ONE  = (D+1)'(1);
   localparam logic [D-1:0] PTR_ONE = D'(1);

   logic [W-1:0] mem_q [DEPTH];
   logic [D-1:0] wr_ptr_q, wr_ptr_d;
   logic [D-1:0] rd_ptr_q, rd_ptr_d;
   logic [D:0]   count_q, count_d;
   logic         ovf_q, ovf_d;
   logic         unf_q, unf_d;
   logic [W-1:0] dout_q, dout_d;
   logic         rd_ok, wr_ok;

   always_comb begin
      rd_ok    = rd_en & ~empty;
      // A full FIFO still takes a write when the same cycle pops a word.
      wr_ok    = wrt_en & (~full | rd_en);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      ovf_d    = wrt_en & full & ~rd_en;
      unf_d    = rd_en & empty;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         dout_d   = mem_q[rd_ptr_q];
      end
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         dout_q   <= dout_d;
      end
   end

   // Storage is deliberately left out of reset; the pointers make stale words unreachable.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   assign data_out     = FWFT ? mem_q[rd_ptr_q] : dout_q;
   assign count        = count_q;
   assign full         = (count_q == CNT_FULL);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CNT_AF);
   assign almost_empty = (count_q <= CNT_AE);
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: registered-read and fall-through instances share stimulus
// and are checked every cycle against a queue model, plus directed literal expectations.
module tb_sync_fifo_flags;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wrt_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] data_in = '0;

   logic [31:0] dout0, dout1;
   logic [3:0]  cnt0, cnt1;
   logic        full0, empty0, af0, ae0, ovf0, unf0;
   logic        full1, empty1, af1, ae1, ovf1, unf1;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_flags #(.W(32), .D(3), .AF_TH(6), .AE_TH(2), .FWFT(1'b0)) u_dut (
      .clk(clk), .rst(rst), .wrt_en(wrt_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(dout0), .count(cnt0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(unf0)
   );

   sync_fifo_flags #(.W(32), .D(3), .AF_TH(6), .AE_TH(2), .FWFT(1'b1)) u_fwft (
      .clk(clk), .rst(rst), .wrt_en(wrt_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(dout1), .count(cnt1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(unf1)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: a queue of at most 8 words.
   logic [31:0] mq[$];
   logic [31:0] mdout = '0;
   bit          movf = 1'b0;
   bit          munf = 1'b0;
   int          mn;
   bit          mrd, mwr;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         mdout = '0;
         movf  = 1'b0;
         munf  = 1'b0;
      end else begin
         mn   = mq.size();
         mrd  = rd_en && (mn > 0);
         mwr  = wrt_en && ((mn < 8) || rd_en);
         movf = wrt_en && (mn == 8) && !rd_en;
         munf = rd_en && (mn == 0);
         if (mrd) mdout = mq.pop_front();
         if (mwr) mq.push_back(data_in);
      end
   end

   task automatic cmp_flags(input string tag, input logic [3:0] c, input logic f, input logic e,
                            input logic af, input logic ae, input logic ov, input logic un);
      int n;
      n = mq.size();
      chk({tag, "_count"}, c, n);
      chk({tag, "_full"}, f, n == 8);
      chk({tag, "_empty"}, e, n == 0);
      chk({tag, "_afull"}, af, n >= 6);
      chk({tag, "_aempty"}, ae, n <= 2);
      chk({tag, "_ovf"}, ov, movf);
      chk({tag, "_unf"}, un, munf);
      chk({tag, "_cnt_le8"}, c <= 4'd8, 1);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_flags("reg", cnt0, full0, empty0, af0, ae0, ovf0, unf0);
         cmp_flags("fwft", cnt1, full1, empty1, af1, ae1, ovf1, unf1);
         chk("reg_dout", dout0, mdout);
         if (mq.size() > 0) chk("fwft_dout", dout1, mq[0]);
      end
   end

   task automatic cyc(input logic we, input logic [31:0] din, input logic re);
      wrt_en  = we;
      data_in = din;
      rd_en   = re;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_count"}, cnt0, 0);
      chk({tag, "_count_f"}, cnt1, 0);
      chk({tag, "_empty"}, empty0 & empty1, 1);
      chk({tag, "_full"}, full0 | full1, 0);
      chk({tag, "_aempty"}, ae0 & ae1, 1);
      chk({tag, "_afull"}, af0 | af1, 0);
      chk({tag, "_ovf"}, ovf0 | ovf1, 0);
      chk({tag, "_unf"}, unf0 | unf1, 0);
      chk({tag, "_dout"}, dout0, 0);
   endtask

   initial begin
      #2 rst = 1'b0;
      #1 chk_en = 1'b1;
      chk_reset_outputs("rst0");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Three writes then three reads.
      cyc(1, 100, 0); chk("s1_cnt_a", cnt0, 1);
      cyc(1, 200, 0); chk("s1_cnt_b", cnt0, 2);
      cyc(1, 300, 0); chk("s1_cnt_c", cnt0, 3);
      cyc(0, 0, 1);   chk("s1_cnt_d", cnt0, 2); chk("s1_dout_a", dout0, 100);
      cyc(0, 0, 1);   chk("s1_cnt_e", cnt0, 1); chk("s1_dout_b", dout0, 200);
      cyc(0, 0, 1);   chk("s1_cnt_f", cnt0, 0); chk("s1_dout_c", dout0, 300);
      chk("s1_empty", empty0, 1);
      cyc(0, 0, 0);

      // Fill, overflow, drain.
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 32'h10 + i, 0);
         chk("s2_cnt", cnt0, i);
         chk("s2_afull", af0, i >= 6);
         chk("s2_full", full0, i == 8);
      end
      cyc(1, 32'hDEAD, 0);
      chk("s2_ovf_hi", ovf0, 1); chk("s2_ovf_cnt", cnt0, 8);
      cyc(0, 0, 0);
      chk("s2_ovf_lo", ovf0, 0);
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 0, 1);
         chk("s2_dout", dout0, 32'h10 + i);
         chk("s2_aempty", ae0, (8 - i) <= 2);
      end
      cyc(0, 0, 0);

      // Simultaneous push/pop while full.
      for (int i = 1; i <= 8; i++) cyc(1, 32'h20 + i, 0);
      cyc(1, 32'hA5, 1);
      chk("s3_cnt", cnt0, 8); chk("s3_pop", dout0, 32'h21); chk("s3_ovf", ovf0, 0);
      for (int i = 2; i <= 8; i++) begin
         cyc(0, 0, 1);
         chk("s3_dout", dout0, 32'h20 + i);
      end
      cyc(0, 0, 1);
      chk("s3_last", dout0, 32'hA5); chk("s3_empty", empty0, 1);
      cyc(0, 0, 0);

      // Underflow alone and with a write.
      cyc(0, 0, 1);
      chk("s4_unf_a", unf0, 1); chk("s4_cnt_a", cnt0, 0); chk("s4_dout_a", dout0, 32'hA5);
      cyc(0, 0, 0);
      chk("s4_unf_lo", unf0, 0);
      cyc(1, 32'h77, 1);
      chk("s4_unf_b", unf0, 1); chk("s4_cnt_b", cnt0, 1); chk("s4_dout_b", dout0, 32'hA5);
      cyc(0, 0, 0);
      chk("s4_unf_lo2", unf0, 0);
      cyc(0, 0, 1);
      chk("s4_drain", dout0, 32'h77); chk("s4_cnt_c", cnt0, 0);
      cyc(0, 0, 0);

      // 20 pushes interleaved with 20 pops; pointers wrap repeatedly.
      for (int i = 0; i < 23; i++) begin
         cyc(i < 20, 32'h100 + i, i >= 3);
         if (i >= 3) chk("s5_order", dout0, 32'h100 + i - 3);
      end
      chk("s5_empty", empty0, 1);
      cyc(0, 0, 0);

      // Fall-through read, then asynchronous reset mid-stream.
      cyc(1, 7, 0);
      chk("s6_fwft_a", dout1, 7);
      cyc(0, 0, 0);
      chk("s6_fwft_b", dout1, 7);
      for (int i = 0; i < 4; i++) cyc(1, 8 + i, 0);
      chk("s6_cnt5", cnt1, 5);
      wrt_en = 1'b0;
      rd_en  = 1'b0;
      #2 rst = 1'b0;
      #1 chk_reset_outputs("s6_async");
      @(posedge clk);
      #1 rst = 1'b1;
      cyc(0, 0, 1);
      chk("s6_post_unf", unf0 & unf1, 1); chk("s6_post_cnt", cnt0, 0);
      cyc(0, 0, 0);
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
